// File: rtl/vc_ctrl_pkg.sv
// Shared types and sizes for the victim-cache controller.
package vc_ctrl_pkg;

  localparam int unsigned VC_ENTRIES = 8;
  localparam int unsigned VC_TAG_W   = 12;

  typedef logic [2:0] vc_idx_t;
  typedef logic [2:0] vc_age_t;

  typedef enum logic [2:0] {
    VC_IDLE,
    VC_LOOKUP,
    VC_SWAP,
    VC_WB,
    VC_INSERT,
    VC_FILL
  } vc_state_t;

endpackage

// File: rtl/vc_ctrl_if.sv
// L1 request/response, data-array control and pmem handshake bundle for vc_ctrl.
interface vc_ctrl_if #(
  parameter int unsigned TAG_W = 12
);

  logic             l1_req;
  logic [TAG_W-1:0] l1_tag;
  logic             l1_evict_valid;
  logic [TAG_W-1:0] l1_evict_tag;
  logic             l1_evict_dirty;
  logic             l1_resp;
  logic             l1_hit;
  logic             l1_line_dirty;
  logic             l1_data_sel;
  logic             arr_write;
  logic [2:0]       arr_index;
  logic             pmem_read;
  logic             pmem_write;
  logic [TAG_W+3:0] pmem_addr;
  logic             pmem_resp;

  // master: L1 + pmem environment; slave: the controller
  modport master (
    output l1_req, l1_tag, l1_evict_valid, l1_evict_tag, l1_evict_dirty, pmem_resp,
    input  l1_resp, l1_hit, l1_line_dirty, l1_data_sel, arr_write, arr_index,
           pmem_read, pmem_write, pmem_addr
  );

  modport slave (
    input  l1_req, l1_tag, l1_evict_valid, l1_evict_tag, l1_evict_dirty, pmem_resp,
    output l1_resp, l1_hit, l1_line_dirty, l1_data_sel, arr_write, arr_index,
           pmem_read, pmem_write, pmem_addr
  );

endinterface

// File: rtl/vc_ctrl_lru.sv
// True-LRU age counters for the victim cache; age 7 marks the least recently used slot.
module vc_lru
  import vc_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    touch_en,
  input  vc_idx_t touch_idx,
  output vc_idx_t lru_idx
);

  vc_age_t age_q [VC_ENTRIES];
  vc_age_t age_d [VC_ENTRIES];

  always_comb begin
    age_d = age_q;
    if (touch_en) begin
      for (int unsigned i = 0; i < VC_ENTRIES; i++) begin
        if (vc_idx_t'(i) == touch_idx) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[touch_idx]) begin
          age_d[i] = age_q[i] + vc_age_t'(1);
        end
      end
    end
  end

  always_comb begin
    lru_idx = '0;
    for (int unsigned i = 0; i < VC_ENTRIES; i++) begin
      if (age_q[i] == '1) lru_idx = vc_idx_t'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < VC_ENTRIES; i++) age_q[i] <= vc_age_t'(i);
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/vc_ctrl.sv
// Victim-cache controller: tag/valid/dirty state, lookup FSM, array and pmem sequencing.
module vc_ctrl
  import vc_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W = VC_TAG_W
) (
  input logic    clk,
  input logic    reset_n,
  vc_ctrl_if.slave bus
);

  vc_state_t state_q, state_d;

  logic [TAG_W-1:0]      req_tag_q, req_tag_d;
  logic                  ev_valid_q, ev_valid_d;
  logic [TAG_W-1:0]      ev_tag_q, ev_tag_d;
  logic                  ev_dirty_q, ev_dirty_d;
  vc_idx_t               idx_q, idx_d;
  logic [VC_ENTRIES-1:0] valid_q, valid_d;
  logic [VC_ENTRIES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q [VC_ENTRIES];
  logic [TAG_W-1:0]      tag_d [VC_ENTRIES];

  logic    hit, inv_found, touch_en;
  vc_idx_t hit_idx, inv_idx, lru_idx, victim;

  logic             l1_resp, l1_hit, l1_line_dirty, l1_data_sel;
  logic             arr_write, pmem_read, pmem_write;
  vc_idx_t          arr_index;
  logic [TAG_W+3:0] pmem_addr;

  vc_lru u_lru (
    .clk       (clk),
    .rst_n     (reset_n),
    .touch_en  (touch_en),
    .touch_idx (idx_q),
    .lru_idx   (lru_idx)
  );

  // Descending scans so the lowest matching index wins.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int unsigned i = VC_ENTRIES; i > 0; i--) begin
      if (valid_q[i-1] && (tag_q[i-1] == req_tag_q)) begin
        hit     = 1'b1;
        hit_idx = vc_idx_t'(i-1);
      end
      if (!valid_q[i-1]) begin
        inv_found = 1'b1;
        inv_idx   = vc_idx_t'(i-1);
      end
    end
    victim = inv_found ? inv_idx : lru_idx;
  end

  always_comb begin
    state_d       = state_q;
    req_tag_d     = req_tag_q;
    ev_valid_d    = ev_valid_q;
    ev_tag_d      = ev_tag_q;
    ev_dirty_d    = ev_dirty_q;
    idx_d         = idx_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    tag_d         = tag_q;
    touch_en      = 1'b0;
    l1_resp       = 1'b0;
    l1_hit        = 1'b0;
    l1_line_dirty = 1'b0;
    l1_data_sel   = 1'b0;
    arr_write     = 1'b0;
    arr_index     = '0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr     = '0;

    unique case (state_q)
      VC_IDLE: begin
        if (bus.l1_req) begin
          req_tag_d  = bus.l1_tag;
          ev_valid_d = bus.l1_evict_valid;
          ev_tag_d   = bus.l1_evict_tag;
          ev_dirty_d = bus.l1_evict_dirty;
          state_d    = VC_LOOKUP;
        end
      end
      VC_LOOKUP: begin
        if (hit) begin
          idx_d   = hit_idx;
          state_d = VC_SWAP;
        end else if (!ev_valid_q) begin
          state_d = VC_FILL;
        end else begin
          idx_d   = victim;
          state_d = (valid_q[victim] && dirty_q[victim]) ? VC_WB : VC_INSERT;
        end
      end
      VC_SWAP: begin
        l1_resp       = 1'b1;
        l1_hit        = 1'b1;
        l1_line_dirty = dirty_q[idx_q];
        arr_index     = idx_q;
        if (ev_valid_q) begin
          arr_write      = 1'b1;
          tag_d[idx_q]   = ev_tag_q;
          dirty_d[idx_q] = ev_dirty_q;
          touch_en       = 1'b1;
        end else begin
          valid_d[idx_q] = 1'b0;
        end
        state_d = VC_IDLE;
      end
      VC_WB: begin
        pmem_write = 1'b1;
        pmem_addr  = {tag_q[idx_q], 4'b0000};
        arr_index  = idx_q;
        if (bus.pmem_resp) state_d = VC_INSERT;
      end
      VC_INSERT: begin
        arr_write      = 1'b1;
        arr_index      = idx_q;
        tag_d[idx_q]   = ev_tag_q;
        valid_d[idx_q] = 1'b1;
        dirty_d[idx_q] = ev_dirty_q;
        touch_en       = 1'b1;
        state_d        = VC_FILL;
      end
      VC_FILL: begin
        pmem_read   = 1'b1;
        pmem_addr   = {req_tag_q, 4'b0000};
        l1_data_sel = 1'b1;
        if (bus.pmem_resp) begin
          l1_resp = 1'b1;
          state_d = VC_IDLE;
        end
      end
      default: state_d = VC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= VC_IDLE;
      req_tag_q  <= '0;
      ev_valid_q <= 1'b0;
      ev_tag_q   <= '0;
      ev_dirty_q <= 1'b0;
      idx_q      <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      for (int unsigned i = 0; i < VC_ENTRIES; i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      req_tag_q  <= req_tag_d;
      ev_valid_q <= ev_valid_d;
      ev_tag_q   <= ev_tag_d;
      ev_dirty_q <= ev_dirty_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
    end
  end

  assign bus.l1_resp       = l1_resp;
  assign bus.l1_hit        = l1_hit;
  assign bus.l1_line_dirty = l1_line_dirty;
  assign bus.l1_data_sel   = l1_data_sel;
  assign bus.arr_write     = arr_write;
  assign bus.arr_index     = arr_index;
  assign bus.pmem_read     = pmem_read;
  assign bus.pmem_write    = pmem_write;
  assign bus.pmem_addr     = pmem_addr;

endmodule

// File: tb/tb_vc_ctrl.sv
// Scoreboard bench for vc_ctrl against an LRU-list victim-cache reference model.
module tb_vc_ctrl;
  import vc_ctrl_pkg::*;

  localparam int unsigned TW = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  vc_ctrl_if #(.TAG_W(TW)) bus ();

  vc_ctrl #(.TAG_W(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_WB, EV_ARR, EV_FILL, EV_RESP} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       idx;
    int       addr;
    bit       hit;
    bit       dirty;
    bit       sel;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  failures = 0;

  // Reference model: entry contents plus a recency list (front = most recent).
  bit m_valid [8];
  int m_tag   [8];
  bit m_dirty [8];
  int m_lru[$];

  int pmem_lat = -1;
  int exp_wb_len = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lru.delete();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_dirty[i] = 1'b0;
      m_lru.push_back(i);
    end
  endtask

  task automatic model_touch(input int i);
    int pos;
    pos = 0;
    for (int p = 0; p < m_lru.size(); p++) if (m_lru[p] == i) pos = p;
    m_lru.delete(pos);
    m_lru.push_front(i);
  endtask

  task automatic push_ev(input ev_kind_e k, input int idx, input int addr,
                         input bit hit, input bit dirty, input bit sel);
    ev_t e;
    e.kind = k; e.idx = idx; e.addr = addr; e.hit = hit; e.dirty = dirty; e.sel = sel;
    sb.push_back(e);
  endtask

  function automatic bit resident(input int tag);
    for (int i = 0; i < 8; i++) if (m_valid[i] && m_tag[i] == tag) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_req(input int tag, input bit evv, input int evt, input bit evd,
                           output bit h);
    int hi, v;
    bit od;
    hi = -1;
    for (int i = 0; i < 8; i++) if (m_valid[i] && m_tag[i] == tag) hi = i;
    if (hi >= 0) begin
      h  = 1'b1;
      od = m_dirty[hi];
      if (evv) begin
        push_ev(EV_ARR, hi, 0, 0, 0, 0);
        m_tag[hi]   = evt;
        m_dirty[hi] = evd;
        model_touch(hi);
      end else begin
        m_valid[hi] = 1'b0;
      end
      push_ev(EV_RESP, hi, 0, 1'b1, od, 1'b0);
    end else begin
      h = 1'b0;
      if (evv) begin
        v = -1;
        for (int i = 7; i >= 0; i--) if (!m_valid[i]) v = i;
        if (v < 0) v = m_lru[7];
        if (m_valid[v] && m_dirty[v]) push_ev(EV_WB, v, m_tag[v] << 4, 0, 0, 0);
        push_ev(EV_ARR, v, 0, 0, 0, 0);
        m_valid[v] = 1'b1;
        m_tag[v]   = evt;
        m_dirty[v] = evd;
        model_touch(v);
      end
      push_ev(EV_FILL, 0, tag << 4, 0, 0, 1'b1);
      push_ev(EV_RESP, 0, 0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic observe(input ev_t g);
    ev_t e;
    bit  ok;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s idx=%0d addr=%h (nothing expected)", g.kind.name(), g.idx, g.addr);
      return;
    end
    e  = sb.pop_front();
    ok = (g.kind == e.kind);
    if (ok) begin
      case (e.kind)
        EV_WB:   ok = (g.idx == e.idx) && (g.addr == e.addr);
        EV_ARR:  ok = (g.idx == e.idx);
        EV_FILL: ok = (g.addr == e.addr) && (g.sel == e.sel);
        default: ok = (g.hit == e.hit) && (g.dirty == e.dirty) && (g.sel == e.sel) &&
                      (!e.hit || g.idx == e.idx);
      endcase
    end
    if (!ok) begin
      failures++;
      $display("FAIL event got %s idx=%0d addr=%h hit=%b dirty=%b sel=%b want %s idx=%0d addr=%h hit=%b dirty=%b sel=%b",
               g.kind.name(), g.idx, g.addr, g.hit, g.dirty, g.sel,
               e.kind.name(), e.idx, e.addr, e.hit, e.dirty, e.sel);
    end
  endtask

  // Monitor: samples DUT outputs on the falling edge.
  bit prev_w = 0, prev_r = 0;
  int wb_cnt = 0;
  always @(negedge clk) begin
    ev_t g;
    if (!reset_n) begin
      prev_w = 0; prev_r = 0; wb_cnt = 0;
    end else begin
      g.idx = int'(bus.arr_index); g.addr = int'(bus.pmem_addr);
      g.hit = bus.l1_hit; g.dirty = bus.l1_line_dirty; g.sel = bus.l1_data_sel;
      if (bus.pmem_read || bus.pmem_write) chk("pmem_rd_wr_exclusive", int'(bus.pmem_read && bus.pmem_write), 0);
      if (bus.pmem_write && !prev_w) begin g.kind = EV_WB;   observe(g); end
      if (bus.arr_write)             begin g.kind = EV_ARR;  observe(g); end
      if (bus.pmem_read && !prev_r)  begin g.kind = EV_FILL; observe(g); end
      if (bus.l1_resp)               begin g.kind = EV_RESP; observe(g); end
      if (bus.pmem_write) wb_cnt++;
      else begin
        if (prev_w && exp_wb_len != 0) chk("wb_hold_cycles", wb_cnt, exp_wb_len);
        wb_cnt = 0;
      end
      prev_w = bus.pmem_write;
      prev_r = bus.pmem_read;
    end
  end

  // pmem responder: one-cycle resp after a per-transaction latency.
  bit busy = 0;
  int cnt = 0, cur = 0;
  always begin
    @(posedge clk);
    #1;
    if (!reset_n) begin
      bus.pmem_resp = 1'b0; busy = 0;
    end else if (bus.pmem_resp) begin
      bus.pmem_resp = 1'b0; busy = 0;
    end else if (bus.pmem_read || bus.pmem_write) begin
      if (!busy) begin
        busy = 1; cnt = 0;
        cur = (pmem_lat < 0) ? int'($urandom_range(0, 3)) : pmem_lat;
      end
      if (cnt >= cur) bus.pmem_resp = 1'b1;
      else cnt++;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_l1_resp"},    int'(bus.l1_resp), 0);
    chk({tag, "_l1_hit"},     int'(bus.l1_hit), 0);
    chk({tag, "_data_sel"},   int'(bus.l1_data_sel), 0);
    chk({tag, "_arr_write"},  int'(bus.arr_write), 0);
    chk({tag, "_arr_index"},  int'(bus.arr_index), 0);
    chk({tag, "_pmem_read"},  int'(bus.pmem_read), 0);
    chk({tag, "_pmem_write"}, int'(bus.pmem_write), 0);
    chk({tag, "_pmem_addr"},  int'(bus.pmem_addr), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.l1_req = 1'b0;
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
  endtask

  task automatic do_req(input int tag, input bit evv, input int evt, input bit evd);
    bit h;
    int cyc;
    model_req(tag, evv, evt, evd, h);
    @(negedge clk);
    bus.l1_req = 1'b1;
    bus.l1_tag = TW'(tag);
    bus.l1_evict_valid = evv;
    bus.l1_evict_tag = TW'(evt);
    bus.l1_evict_dirty = evd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.l1_resp && cyc < 200);
    chk("req_completes", int'(bus.l1_resp), 1);
    if (h) chk("hit_latency", cyc, 2);
    @(posedge clk);
    #1 bus.l1_req = 1'b0;
  endtask

  initial begin
    bit dummy;
    int tag, evt, cyc;
    bit evv;
    bus.l1_req = 1'b0; bus.l1_tag = '0; bus.l1_evict_valid = 1'b0;
    bus.l1_evict_tag = '0; bus.l1_evict_dirty = 1'b0; bus.pmem_resp = 1'b0;
    model_reset();

    // 1: plain miss with no victim
    do_reset();
    do_req(12'h010, 0, 0, 0);

    // 2: clean victim into empty VC, then hit on it
    do_req(12'h011, 1, 12'h123, 0);
    do_req(12'h123, 1, 12'h124, 0);

    // 3: fill all slots, hit-swap slot 0, then a miss evicts slot 1
    do_reset();
    for (int i = 0; i < 8; i++) do_req(12'h100 + i, 1, 12'h200 + i, 0);
    do_req(12'h200, 1, 12'h300, 0);
    do_req(12'h500, 1, 12'h400, 0);

    // 4: dirty LRU victim written back with a 5-cycle pmem_write
    do_reset();
    do_req(12'h0A0, 1, 12'h2A5, 1);
    for (int i = 1; i < 8; i++) do_req(12'h0A0 + i, 1, 12'h2A5 + i, 0);
    pmem_lat = 4; exp_wb_len = 5;
    do_req(12'h050, 1, 12'h555, 1);
    pmem_lat = -1; exp_wb_len = 0;

    // 5: hit without a victim invalidates the slot
    do_req(12'h2A7, 0, 0, 0);
    do_req(12'h2A7, 0, 0, 0);

    // 6: reset asserted while in writeback
    do_reset();
    for (int i = 0; i < 8; i++) do_req(12'h0B0 + i, 1, 12'h600 + i, 1);
    pmem_lat = 1000;
    model_req(12'h0C0, 1, 12'h700, 0, dummy);
    @(negedge clk);
    bus.l1_req = 1'b1; bus.l1_tag = 12'h0C0; bus.l1_evict_valid = 1'b1;
    bus.l1_evict_tag = 12'h700; bus.l1_evict_dirty = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.pmem_write && cyc < 20);
    chk("wb_reached", int'(bus.pmem_write), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_pmem_write", int'(bus.pmem_write), 0);
    chk("async_rst_l1_resp", int'(bus.l1_resp), 0);
    bus.l1_req = 1'b0;
    sb.delete();
    model_reset();
    pmem_lat = -1;
    @(negedge clk);
    reset_n = 1'b1;
    do_req(12'h600, 1, 12'h601, 0);
    do_req(12'h601, 0, 0, 0);

    // Randomized traffic over a small tag pool so hits and evictions mix
    do_reset();
    for (int n = 0; n < 200; n++) begin
      tag = 12'h0C0 + int'($urandom_range(0, 15));
      evv = ($urandom_range(0, 3) != 0);
      do evt = 12'h0C0 + int'($urandom_range(0, 15));
      while (resident(evt) || evt == tag);
      do_req(tag, evv, evt, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
